// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the boot-time program loader: FSM state encodings
//   and the number of stream bytes packed into one memory word.
package program_loader_pkg;

    localparam logic [2:0] LD_IDLE  = 3'd0;
    localparam logic [2:0] LD_RECV  = 3'd1;
    localparam logic [2:0] LD_WRITE = 3'd2;
    localparam logic [2:0] LD_HOLD  = 3'd3;
    localparam logic [2:0] LD_RUN   = 3'd4;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_word_packer.sv
// word_packer
//   Packs stream bytes MSB-first into a 32-bit word.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     clear_i        drop any partial word and restart at byte 0
//     push_i         a byte is being accepted this cycle
//     byte_i         the byte being accepted
//     word_o         packed word including the byte currently pushed
//     word_full_o    this push completes a word
module word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    // Only the first three bytes are stored; the fourth is taken straight
    // from the stream so the finished word is available in the cycle it
    // completes and can be registered for the WRITE cycle that follows.
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (push_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;   // wraps 3 -> 0 at word boundary
        end
    end

    assign word_o      = {shift_q, byte_i};
    assign word_full_o = push_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Boot-time writer for the CPU's unified memory. Accepts a byte stream,
//   packs 4 bytes MSB-first per word, writes words to consecutive word
//   addresses from 0, and holds the CPU in reset until the load completes.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     load_start_i        pulse: start a load of load_len_i words (IDLE/RUN only)
//     load_len_i          number of words to load
//     byte_in_i/valid_i   stream byte and its valid
//     byte_ready_o        stream byte accepted this cycle when valid
//     mem_wr_en_o/addr_o/data_o   memory write port
//     cpu_reset_o         CPU reset, low only in RUN
//     busy_o              load in progress (RECV, WRITE, HOLD)
//     checksum_o          XOR of the words written by the current load
//   All outputs are registered and derived from the next state.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_HOLD = 2     // 1..15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    input  logic [7:0]            byte_in_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [31:0]           mem_wr_data_o,
    output logic                  cpu_reset_o,
    output logic                  busy_o,
    output logic [31:0]           checksum_o
);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d, wcnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            hold_q, hold_d;
    logic [31:0]           csum_q, csum_d;
    logic [31:0]           data_q, data_d;
    logic                  ready_q, wr_en_q, cpu_reset_q, busy_q;

    logic                  start, push, word_full;
    logic [31:0]           word;

    word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start),
        .push_i      (push),
        .byte_i      (byte_in_i),
        .word_o      (word),
        .word_full_o (word_full)
    );

    assign wcnt_inc = wcnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        csum_d  = csum_q;
        data_d  = data_q;
        start   = 1'b0;
        push    = 1'b0;
        case (state_q)
            LD_IDLE, LD_RUN: begin
                if (load_start_i) begin
                    start   = 1'b1;
                    len_d   = load_len_i;
                    wcnt_d  = '0;
                    addr_d  = '0;
                    hold_d  = '0;
                    csum_d  = '0;
                    state_d = (load_len_i == '0) ? LD_HOLD : LD_RECV;
                end
            end
            LD_RECV: begin
                // ready_q is the registered byte_ready output, so the
                // handshake matches what the source sees.
                push = byte_valid_i && ready_q;
                if (word_full) begin
                    data_d  = word;
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                csum_d = csum_q ^ data_q;
                addr_d = addr_q + 1'b1;      // natural wrap at 2^ADDR_WIDTH
                wcnt_d = wcnt_inc;
                if (wcnt_inc == len_q) begin
                    hold_d  = '0;
                    state_d = LD_HOLD;
                end else begin
                    state_d = LD_RECV;
                end
            end
            LD_HOLD: begin
                if (hold_q == 4'(RESET_HOLD - 1)) state_d = LD_RUN;
                else                              hold_d  = hold_q + 4'd1;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LD_IDLE;
            len_q       <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            hold_q      <= '0;
            csum_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            csum_q      <= csum_d;
            data_q      <= data_d;
            ready_q     <= (state_d == LD_RECV);
            wr_en_q     <= (state_d == LD_WRITE);
            cpu_reset_q <= (state_d != LD_RUN);
            busy_q      <= (state_d == LD_RECV) || (state_d == LD_WRITE) ||
                           (state_d == LD_HOLD);
        end
    end

    assign byte_ready_o  = ready_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = addr_q;
    assign mem_wr_data_o = data_q;
    assign cpu_reset_o   = cpu_reset_q;
    assign busy_o        = busy_q;
    assign checksum_o    = csum_q;

endmodule
